sram1rw_arbiter: RTL and testbench
==================================

# sram1rw_arbiter

Two-requester round-robin controller for one 32x50 single-port SRAM macro (SRAM1RW32x50-class: active-low CSB/WEB/OEB, read data registered inside the macro on the clock edge). After reset it clears the array, then serves read and write requests from two clients. Each client uses valid/ready handshakes and has a 1-entry read-response buffer, so a client that stalls its response does not block the other client. It sits between the cache or datapath clients and the hard macro, whose CE is driven by the same `clock`.

## Interface
Parameters:
- `DATA_W`, 50: macro word width.
- `ADDR_W`, 5: macro address width.
- `DEPTH`, 32: number of words. Must equal 2^ADDR_W.
- `INIT_EN`, 1: when 1, clear the array after reset.
- `INIT_VALUE`, 0: word written to every entry during clear.

Ports:
- `clock` in 1: single clock. Also drives the macro CE at top level.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 2: per-client request valid.
- `req_ready` out 2: per-client request accepted this cycle.
- `req_we` in 2: 1 = write, 0 = read.
- `req_addr` in 2*ADDR_W: client p uses slice [p*ADDR_W +: ADDR_W].
- `req_wdata` in 2*DATA_W: write data per client.
- `resp_valid` out 2: read data held for client.
- `resp_ready` in 2: client consumes response.
- `resp_rdata` out 2*DATA_W: read data per client.
- `init_done` out 1: high once clear has finished. Tied high when INIT_EN=0.
- `sram_csb`, `sram_web`, `sram_oeb` out 1 each: macro controls, active-low.
- `sram_a` out ADDR_W: macro address.
- `sram_i` out DATA_W: macro write data.
- `sram_o` in DATA_W: macro read data.

## Operation
FSM states:
- `S_INIT`
  - Entered on reset when INIT_EN=1. A 5-bit counter writes INIT_VALUE to addresses 0..DEPTH-1, one per cycle: csb=0, web=0, oeb=1.
  - `req_ready`=0 throughout.
  - After writing address DEPTH-1, go to `S_RUN` and set `init_done`=1.
- `S_RUN`
  - Client p is eligible when `req_valid[p]` and either `req_we[p]`=1, or `pend[p]`=0.
  - `pend[p]` means a read is in flight or held in client p's response buffer.
  - Exception: `pend[p]` is cleared in the same cycle when the only pending item is the held response and `resp_ready[p]`=1 (same-cycle drain and reissue).
  - Round-robin between eligible clients. Pointer resets to client 0; after a grant, it points to the other client.
  - At most one grant per cycle. `req_ready[p]`=1 exactly for the granted client.
  - A granted access drives the macro combinationally in that cycle:
    - Read: csb=0, web=1, oeb=0.
    - Write: csb=0, web=0, oeb=1.
  - No grant: csb=web=oeb=1. `sram_a` and `sram_i` don't-care (hold last value).
- Read return path:
  - A read granted in cycle N records owner p in a 1-stage in-flight register.
  - At the end of N+1, `sram_o` is captured into `resp_rdata[p]` and `resp_valid[p]` rises.
  - `resp_valid[p]` clears on `resp_valid & resp_ready`.
- Writes need no response. A client may write while its read is pending.
- Same-address ordering: accesses complete in grant order. A read granted at N returns pre-write data for a write granted at N+1.
- `reset` asserted mid-operation:
  - Next cycle: state=`S_INIT` (or `S_RUN` if INIT_EN=0), `pend`=0, `resp_valid`=0, in-flight cleared, pointer=0, init counter=0.
  - In-flight data is discarded.

## Timing
- Reset values:
  - `req_ready`=0, `resp_valid`=0, `resp_rdata`=0.
  - `init_done`=0 (1 if INIT_EN=0).
  - `sram_csb`=1, `sram_web`=1, `sram_oeb`=1, `sram_a`=0, `sram_i`=0.
- Clear takes exactly DEPTH cycles. `init_done` rises in the cycle after the write to address DEPTH-1.
- Read latency: grant in cycle N, `resp_valid` high in N+2.
- Per-client read throughput: one read per 2 cycles with `resp_ready` tied high.
- Aggregate throughput: 1 access per cycle when both clients are active.
- `req_ready` depends combinationally on `req_valid`, `req_we`, `resp_ready`, and state.
- No combinational path exists from `sram_o` to any output.

## Structure
- Package `sram_arb_pkg`: `DATA_W`/`ADDR_W`/`DEPTH` defaults, `NUM_CLIENTS`=2, state enum {S_INIT, S_RUN}.
- Sub-module `rr_arb2`: 2-way round-robin pick with pointer register. Inputs are eligible[1:0] and a grant-accepted strobe; output is one-hot grant.
- The top level holds the FSM, init counter, in-flight tag, and per-client response buffers.

## Test plan
- Reset, then read all 32 addresses from client 0 -> `init_done` rises 32 cycles after reset deasserts; every read returns 0, each 2 cycles after its grant.
- Client 0 writes 0x3_FFFF_FFFF_FFFF to address 7, then client 1 reads address 7 -> client 1 receives 0x3_FFFF_FFFF_FFFF.
- Both clients request reads every cycle with `resp_ready`=1 -> grants alternate 0,1,0,1, and one macro access occurs per cycle.
- Client 1 holds `resp_ready`=0 with a pending read -> its further reads stall (`req_ready[1]`=0), its writes still proceed, and client 0 reads are unaffected. Release `resp_ready` -> the held data drains and a new read is granted in the same cycle.
- Read address 3 at cycle N, client 1 writes 0x155 to address 3 at N+1 -> the read returns the old value, and a later read returns 0x155.
- Assert `reset` in the cycle after a read grant -> no `resp_valid` appears, and the FSM re-enters `S_INIT` with the counter at 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-client SRAM round-robin controller.
package sram_arb_pkg;

  localparam int DEFAULT_DATA_W = 50;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_DEPTH  = 32;
  localparam int NUM_CLIENTS    = 2;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. The pointer names the client preferred when
// both are eligible; after any accepted grant it moves to the other client.
module rr_arb2 (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [1:0] eligible_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  // Pick one eligible client; contention is resolved by the pointer.
  always_comb begin
    grant_o = 2'b00;
    unique case (eligible_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // Move the preference away from whichever client just won.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_i && (grant_o != 2'b00)) begin
      ptr_d = ~grant_o[1];
    end
  end

  // Pointer register, back to client 0 on reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sram1rw_arbiter.sv
// Round-robin front end for one single-port SRAM macro shared by two clients.
// Clears the array after reset, then grants at most one access per cycle.
// Read data comes back from the macro one cycle after the grant and is parked
// in a per-client response register until that client takes it.
module sram1rw_arbiter
  import sram_arb_pkg::*;
#(
  parameter int                DATA_W     = DEFAULT_DATA_W,
  parameter int                ADDR_W     = DEFAULT_ADDR_W,
  parameter int                DEPTH      = DEFAULT_DEPTH,
  parameter bit                INIT_EN    = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        req_valid,
  output logic [NUM_CLIENTS-1:0]        req_ready,
  input  logic [NUM_CLIENTS-1:0]        req_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] req_wdata,
  output logic [NUM_CLIENTS-1:0]        resp_valid,
  input  logic [NUM_CLIENTS-1:0]        resp_ready,
  output logic [NUM_CLIENTS*DATA_W-1:0] resp_rdata,
  output logic                          init_done,
  output logic                          sram_csb,
  output logic                          sram_web,
  output logic                          sram_oeb,
  output logic [ADDR_W-1:0]             sram_a,
  output logic [DATA_W-1:0]             sram_i,
  input  logic [DATA_W-1:0]             sram_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e                        state_q, state_d;
  logic [ADDR_W-1:0]             initCnt_q, initCnt_d;
  logic                          inflightValid_q, inflightValid_d;
  logic                          inflightOwner_q, inflightOwner_d;
  logic [NUM_CLIENTS-1:0]        respValid_q, respValid_d;
  logic [NUM_CLIENTS*DATA_W-1:0] respData_q, respData_d;
  logic [ADDR_W-1:0]             addrHold_q;
  logic [DATA_W-1:0]             dataHold_q;

  logic                   runActive;
  logic [NUM_CLIENTS-1:0] pendBlock;
  logic [NUM_CLIENTS-1:0] eligible;
  logic [NUM_CLIENTS-1:0] grant;
  logic                   winner;
  logic                   selWe;
  logic [ADDR_W-1:0]      selAddr;
  logic [DATA_W-1:0]      selData;
  logic                   csb, web, oeb;
  logic [ADDR_W-1:0]      addrOut;
  logic [DATA_W-1:0]      dataOut;

  // A client may read only when nothing of its own is outstanding, except that
  // a held response being consumed this very cycle frees the slot immediately.
  always_comb begin
    pendBlock = '0;
    eligible  = '0;
    runActive = (state_q == S_RUN) && !reset;
    for (int p = 0; p < NUM_CLIENTS; p++) begin
      pendBlock[p] = (inflightValid_q && (inflightOwner_q == 1'(p))) ||
                     (respValid_q[p] && !resp_ready[p]);
      eligible[p]  = runActive && req_valid[p] && (req_we[p] || !pendBlock[p]);
    end
  end

  rr_arb2 u_arb (
    .clock_i    (clock),
    .reset_i    (reset),
    .eligible_i (eligible),
    .accept_i   (runActive),
    .grant_o    (grant)
  );

  assign winner  = grant[1];
  assign selWe   = winner ? req_we[1] : req_we[0];
  assign selAddr = winner ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign selData = winner ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  // Sequencing of the clear pass and driving the macro for the granted access.
  always_comb begin
    state_d         = state_q;
    initCnt_d       = initCnt_q;
    inflightValid_d = 1'b0;
    inflightOwner_d = inflightOwner_q;
    csb             = 1'b1;
    web             = 1'b1;
    oeb             = 1'b1;
    addrOut         = addrHold_q;
    dataOut         = dataHold_q;
    unique case (state_q)
      S_INIT: begin
        csb       = 1'b0;
        web       = 1'b0;
        addrOut   = initCnt_q;
        dataOut   = INIT_VALUE;
        initCnt_d = initCnt_q + 1'b1;
        if (initCnt_q == LAST_ADDR) begin
          state_d   = S_RUN;
          initCnt_d = '0;
        end
      end
      S_RUN: begin
        if (grant != '0) begin
          csb     = 1'b0;
          web     = !selWe;
          oeb     = selWe;
          addrOut = selAddr;
          dataOut = selData;
          if (!selWe) begin
            inflightValid_d = 1'b1;
            inflightOwner_d = winner;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
    if (reset) begin
      csb     = 1'b1;
      web     = 1'b1;
      oeb     = 1'b1;
      addrOut = '0;
      dataOut = '0;
    end
  end

  // Response buffers: capture macro output for the in-flight owner, clear on
  // handshake. Capture wins because a new read cannot overlap a held one.
  always_comb begin
    respValid_d = respValid_q;
    respData_d  = respData_q;
    for (int p = 0; p < NUM_CLIENTS; p++) begin
      if (respValid_q[p] && resp_ready[p]) begin
        respValid_d[p] = 1'b0;
      end
      if (inflightValid_q && (inflightOwner_q == 1'(p))) begin
        respValid_d[p]                = 1'b1;
        respData_d[p*DATA_W +: DATA_W] = sram_o;
      end
    end
  end

  // State registers; reset drops any in-flight read and restarts the clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= INIT_EN ? S_INIT : S_RUN;
      initCnt_q       <= '0;
      inflightValid_q <= 1'b0;
      inflightOwner_q <= 1'b0;
      respValid_q     <= '0;
      respData_q      <= '0;
      addrHold_q      <= '0;
      dataHold_q      <= '0;
    end else begin
      state_q         <= state_d;
      initCnt_q       <= initCnt_d;
      inflightValid_q <= inflightValid_d;
      inflightOwner_q <= inflightOwner_d;
      respValid_q     <= respValid_d;
      respData_q      <= respData_d;
      addrHold_q      <= addrOut;
      dataHold_q      <= dataOut;
    end
  end

  assign req_ready  = grant;
  assign resp_valid = respValid_q;
  assign resp_rdata = respData_q;
  assign init_done  = INIT_EN ? ((state_q == S_RUN) && !reset) : 1'b1;
  assign sram_csb   = csb;
  assign sram_web   = web;
  assign sram_oeb   = oeb;
  assign sram_a     = addrOut;
  assign sram_i     = dataOut;

endmodule

// File: tb/tb_sram1rw_arbiter.sv
// Self-checking bench for sram1rw_arbiter with a behavioural SRAM macro and a
// cycle-level reference model of grants, memory contents and responses.
module tb_sram1rw_arbiter;

  localparam int DW    = 50;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      reqValid, reqReady, reqWe, respValid, respReady;
  logic [2*AW-1:0] reqAddr;
  logic [2*DW-1:0] reqWdata, respRdata;
  logic            initDone, sramCsb, sramWeb, sramOeb;
  logic [AW-1:0]   sramA;
  logic [DW-1:0]   sramI, sramO;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] expMem [DEPTH];
  logic [DW-1:0] macroMem [DEPTH];
  logic [DW-1:0] macroQ;

  sram1rw_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_we     (reqWe),
    .req_addr   (reqAddr),
    .req_wdata  (reqWdata),
    .resp_valid (respValid),
    .resp_ready (respReady),
    .resp_rdata (respRdata),
    .init_done  (initDone),
    .sram_csb   (sramCsb),
    .sram_web   (sramWeb),
    .sram_oeb   (sramOeb),
    .sram_a     (sramA),
    .sram_i     (sramI),
    .sram_o     (sramO)
  );

  always #5 clock = ~clock;

  // Behavioural single-port macro: read data registered on the clock edge.
  always @(posedge clock) begin
    if (!sramCsb) begin
      if (!sramWeb) macroMem[sramA] <= sramI;
      else if (!sramOeb) macroQ <= macroMem[sramA];
    end
  end
  assign sramO = macroQ;

  function automatic logic [DW-1:0] rdataOf(input int p);
    return respRdata[p*DW +: DW];
  endfunction

  task automatic setReq(input int p, input logic v, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    reqValid[p]          = v;
    reqWe[p]             = we;
    reqAddr[p*AW +: AW]  = a;
    reqWdata[p*DW +: DW] = d;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; reqValid = 2'b11; reqWe = 2'b00; respReady = 2'b11;
    @(negedge clock); #1;
    checks++; if (reqReady !== 2'b00) begin errors++; $display("[TB] FAIL rst_req_ready got=%b exp=00", reqReady); end
    checks++; if (respValid !== 2'b00) begin errors++; $display("[TB] FAIL rst_resp_valid got=%b exp=00", respValid); end
    checks++; if (respRdata !== '0) begin errors++; $display("[TB] FAIL rst_resp_rdata got=%h exp=0", respRdata); end
    checks++; if (initDone !== 1'b0) begin errors++; $display("[TB] FAIL rst_init_done got=%b exp=0", initDone); end
    checks++; if ({sramCsb, sramWeb, sramOeb} !== 3'b111) begin errors++; $display("[TB] FAIL rst_ctrl got=%b exp=111", {sramCsb, sramWeb, sramOeb}); end
    checks++; if (sramA !== '0 || sramI !== '0) begin errors++; $display("[TB] FAIL rst_addr_data got=%h/%h exp=0/0", sramA, sramI); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_init();
    for (int k = 0; k < DEPTH; k++) begin
      if (k > 0) @(negedge clock);
      checks++; if (initDone !== 1'b0) begin errors++; $display("[TB] FAIL init_done_early k=%0d got=%b exp=0", k, initDone); end
      #1;
      checks++; if (sramA !== AW'(k)) begin errors++; $display("[TB] FAIL init_addr got=%0d exp=%0d", sramA, k); end
      checks++; if ({sramCsb, sramWeb, sramOeb} !== 3'b001) begin errors++; $display("[TB] FAIL init_ctrl got=%b exp=001", {sramCsb, sramWeb, sramOeb}); end
      checks++; if (reqReady !== 2'b00) begin errors++; $display("[TB] FAIL init_req_ready got=%b exp=00", reqReady); end
    end
    @(negedge clock);
    reqValid = 2'b00;
    checks++; if (initDone !== 1'b1) begin errors++; $display("[TB] FAIL init_done_rise got=%b exp=1", initDone); end
    for (int k = 0; k < DEPTH; k++) expMem[k] = '0;
  endtask

  task automatic test_init_reads();
    for (int a = 0; a < DEPTH; a++) begin
      if (a > 0) @(negedge clock);
      checks++; if (respValid !== ((a == 0) ? 2'b00 : 2'b01)) begin errors++; $display("[TB] FAIL rd_all_valid a=%0d got=%b", a, respValid); end
      if (a > 0) begin
        checks++; if (rdataOf(0) !== expMem[a-1]) begin errors++; $display("[TB] FAIL rd_all_data a=%0d got=%h exp=%h", a - 1, rdataOf(0), expMem[a-1]); end
      end
      setReq(0, 1'b1, 1'b0, AW'(a), '0); respReady = 2'b11;
      #1;
      checks++; if (reqReady !== 2'b01) begin errors++; $display("[TB] FAIL rd_all_ready a=%0d got=%b exp=01", a, reqReady); end
      checks++; if (sramOeb !== 1'b0 || sramA !== AW'(a)) begin errors++; $display("[TB] FAIL rd_all_macro oeb=%b a=%0d exp a=%0d", sramOeb, sramA, a); end
      @(negedge clock);
      setReq(0, 1'b0, 1'b0, '0, '0);
      checks++; if (respValid !== 2'b00) begin errors++; $display("[TB] FAIL rd_all_latency a=%0d got=%b exp=00", a, respValid); end
    end
    @(negedge clock);
    checks++; if (respValid !== 2'b01 || rdataOf(0) !== expMem[DEPTH-1]) begin errors++; $display("[TB] FAIL rd_all_last got=%b/%h", respValid, rdataOf(0)); end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] d;
    d = 50'h3_FFFF_FFFF_FFFF;
    @(negedge clock);
    setReq(0, 1'b1, 1'b1, 5'd7, d);
    #1;
    checks++; if (reqReady !== 2'b01) begin errors++; $display("[TB] FAIL wr7_ready got=%b exp=01", reqReady); end
    checks++; if (sramWeb !== 1'b0 || sramA !== 5'd7 || sramI !== d) begin errors++; $display("[TB] FAIL wr7_macro web=%b a=%0d i=%h", sramWeb, sramA, sramI); end
    expMem[7] = d;
    @(negedge clock);
    setReq(0, 1'b0, 1'b0, '0, '0);
    setReq(1, 1'b1, 1'b0, 5'd7, '0);
    #1;
    checks++; if (reqReady !== 2'b10) begin errors++; $display("[TB] FAIL rd7_ready got=%b exp=10", reqReady); end
    @(negedge clock);
    setReq(1, 1'b0, 1'b0, '0, '0);
    checks++; if (respValid !== 2'b00) begin errors++; $display("[TB] FAIL rd7_early got=%b exp=00", respValid); end
    @(negedge clock);
    checks++; if (respValid !== 2'b10 || rdataOf(1) !== d) begin errors++; $display("[TB] FAIL rd7_data got=%b/%h exp=10/%h", respValid, rdataOf(1), d); end
  endtask

  task automatic test_alternating();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      respReady = 2'b11;
      if (i >= 2) begin
        checks++; if (respValid !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL alt_valid i=%0d got=%b", i, respValid); end
        if (i % 2 == 0) begin
          checks++; if (rdataOf(0) !== expMem[7]) begin errors++; $display("[TB] FAIL alt_data0 got=%h exp=%h", rdataOf(0), expMem[7]); end
        end else begin
          checks++; if (rdataOf(1) !== expMem[3]) begin errors++; $display("[TB] FAIL alt_data1 got=%h exp=%h", rdataOf(1), expMem[3]); end
        end
      end else begin
        checks++; if (respValid !== 2'b00) begin errors++; $display("[TB] FAIL alt_valid_start i=%0d got=%b", i, respValid); end
      end
      setReq(0, i < 8, 1'b0, 5'd7, '0);
      setReq(1, i < 8, 1'b0, 5'd3, '0);
      #1;
      if (i < 8) begin
        checks++; if (reqReady !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL alt_grant i=%0d got=%b", i, reqReady); end
        checks++; if (sramCsb !== 1'b0) begin errors++; $display("[TB] FAIL alt_csb i=%0d got=%b exp=0", i, sramCsb); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d9;
    d9 = 50'h2_AAAA_5555_AAAA;
    @(negedge clock);  // c0
    respReady = 2'b01;
    setReq(1, 1'b1, 1'b0, 5'd7, '0);
    #1; checks++; if (reqReady !== 2'b10) begin errors++; $display("[TB] FAIL bp_c0 got=%b exp=10", reqReady); end
    @(negedge clock);  // c1
    setReq(0, 1'b1, 1'b0, 5'd5, '0);
    setReq(1, 1'b1, 1'b0, 5'd0, '0);
    #1; checks++; if (reqReady !== 2'b01) begin errors++; $display("[TB] FAIL bp_c1 got=%b exp=01", reqReady); end
    @(negedge clock);  // c2
    setReq(0, 1'b0, 1'b0, '0, '0);
    checks++; if (respValid !== 2'b10 || rdataOf(1) !== expMem[7]) begin errors++; $display("[TB] FAIL bp_c2_held got=%b/%h", respValid, rdataOf(1)); end
    #1; checks++; if (reqReady !== 2'b00) begin errors++; $display("[TB] FAIL bp_c2_stall got=%b exp=00", reqReady); end
    @(negedge clock);  // c3
    setReq(1, 1'b1, 1'b1, 5'd9, d9);
    checks++; if (respValid !== 2'b11 || rdataOf(0) !== expMem[5]) begin errors++; $display("[TB] FAIL bp_c3_c0 got=%b/%h", respValid, rdataOf(0)); end
    #1; checks++; if (reqReady !== 2'b10) begin errors++; $display("[TB] FAIL bp_c3_write got=%b exp=10", reqReady); end
    expMem[9] = d9;
    @(negedge clock);  // c4
    setReq(0, 1'b1, 1'b0, 5'd9, '0);
    setReq(1, 1'b1, 1'b0, 5'd7, '0);
    checks++; if (respValid !== 2'b10) begin errors++; $display("[TB] FAIL bp_c4_valid got=%b exp=10", respValid); end
    #1; checks++; if (reqReady !== 2'b01) begin errors++; $display("[TB] FAIL bp_c4 got=%b exp=01", reqReady); end
    @(negedge clock);  // c5
    respReady = 2'b11;
    setReq(0, 1'b0, 1'b0, '0, '0);
    setReq(1, 1'b1, 1'b0, 5'd9, '0);
    checks++; if (respValid !== 2'b10 || rdataOf(1) !== expMem[7]) begin errors++; $display("[TB] FAIL bp_c5_held got=%b/%h", respValid, rdataOf(1)); end
    #1; checks++; if (reqReady !== 2'b10) begin errors++; $display("[TB] FAIL bp_c5_reissue got=%b exp=10", reqReady); end
    @(negedge clock);  // c6
    setReq(1, 1'b0, 1'b0, '0, '0);
    checks++; if (respValid !== 2'b01 || rdataOf(0) !== d9) begin errors++; $display("[TB] FAIL bp_c6 got=%b/%h exp=01/%h", respValid, rdataOf(0), d9); end
    @(negedge clock);  // c7
    checks++; if (respValid !== 2'b10 || rdataOf(1) !== d9) begin errors++; $display("[TB] FAIL bp_c7 got=%b/%h exp=10/%h", respValid, rdataOf(1), d9); end
    @(negedge clock);  // c8
    checks++; if (respValid !== 2'b00) begin errors++; $display("[TB] FAIL bp_c8 got=%b exp=00", respValid); end
  endtask

  task automatic test_ordering();
    logic [DW-1:0] oldVal;
    oldVal = expMem[3];
    @(negedge clock);
    setReq(0, 1'b1, 1'b0, 5'd3, '0);
    #1; checks++; if (reqReady !== 2'b01) begin errors++; $display("[TB] FAIL ord_rd got=%b exp=01", reqReady); end
    @(negedge clock);
    setReq(0, 1'b0, 1'b0, '0, '0);
    setReq(1, 1'b1, 1'b1, 5'd3, 50'h155);
    #1; checks++; if (reqReady !== 2'b10) begin errors++; $display("[TB] FAIL ord_wr got=%b exp=10", reqReady); end
    expMem[3] = 50'h155;
    @(negedge clock);
    setReq(1, 1'b0, 1'b0, '0, '0);
    checks++; if (respValid !== 2'b01 || rdataOf(0) !== oldVal) begin errors++; $display("[TB] FAIL ord_old got=%b/%h exp=01/%h", respValid, rdataOf(0), oldVal); end
    setReq(0, 1'b1, 1'b0, 5'd3, '0);
    @(negedge clock);
    setReq(0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    checks++; if (respValid !== 2'b01 || rdataOf(0) !== 50'h155) begin errors++; $display("[TB] FAIL ord_new got=%b/%h exp=01/155", respValid, rdataOf(0)); end
  endtask

  task automatic test_random();
    bit            pending [2];
    int            readyAt [2];
    logic [DW-1:0] pendData [2];
    int            lastGrant;
    int            g;
    logic [1:0]    expValid, elig, expGrant;
    logic [DW-1:0] d;
    @(negedge clock);
    reset = 1'b1; reqValid = 2'b00; respReady = 2'b11;
    @(negedge clock);
    reset = 1'b0;
    repeat (DEPTH) @(negedge clock);
    checks++; if (initDone !== 1'b1) begin errors++; $display("[TB] FAIL rnd_init got=%b exp=1", initDone); end
    for (int k = 0; k < DEPTH; k++) expMem[k] = '0;
    for (int p = 0; p < 2; p++) begin pending[p] = 1'b0; readyAt[p] = 0; pendData[p] = '0; end
    lastGrant = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clock);
      for (int p = 0; p < 2; p++) expValid[p] = pending[p] && (cyc >= readyAt[p]);
      checks++; if (respValid !== expValid) begin errors++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, respValid, expValid); end
      for (int p = 0; p < 2; p++) begin
        if (expValid[p]) begin
          checks++; if (rdataOf(p) !== pendData[p]) begin errors++; $display("[TB] FAIL rnd_data cyc=%0d p=%0d got=%h exp=%h", cyc, p, rdataOf(p), pendData[p]); end
        end
      end
      respReady = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        d = DW'({$urandom(), $urandom()});
        setReq(p, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, AW'($urandom_range(0, DEPTH - 1)), d);
      end
      for (int p = 0; p < 2; p++) begin
        elig[p] = reqValid[p] && (reqWe[p] || !pending[p] || ((cyc >= readyAt[p]) && respReady[p]));
      end
      if (elig == 2'b11) expGrant = (lastGrant == 0) ? 2'b10 : 2'b01;
      else expGrant = elig;
      #1;
      checks++; if (reqReady !== expGrant) begin errors++; $display("[TB] FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, reqReady, expGrant); end
      checks++; if (sramCsb !== (expGrant == 2'b00)) begin errors++; $display("[TB] FAIL rnd_csb cyc=%0d got=%b", cyc, sramCsb); end
      for (int p = 0; p < 2; p++) if (expValid[p] && respReady[p]) pending[p] = 1'b0;
      if (expGrant != 2'b00) begin
        g = expGrant[1] ? 1 : 0;
        lastGrant = g;
        if (reqWe[g]) begin
          expMem[reqAddr[g*AW +: AW]] = reqWdata[g*DW +: DW];
        end else begin
          pending[g]  = 1'b1;
          readyAt[g]  = cyc + 2;
          pendData[g] = expMem[reqAddr[g*AW +: AW]];
        end
      end
    end
    @(negedge clock);
    reqValid = 2'b00; respReady = 2'b11;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset_midop();
    int waited;
    @(negedge clock);
    setReq(0, 1'b1, 1'b0, 5'd7, '0); respReady = 2'b11;
    #1; checks++; if (reqReady !== 2'b01) begin errors++; $display("[TB] FAIL mid_grant got=%b exp=01", reqReady); end
    @(negedge clock);
    setReq(0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (respValid !== 2'b00) begin errors++; $display("[TB] FAIL mid_no_resp got=%b exp=00", respValid); end
    checks++; if (initDone !== 1'b0) begin errors++; $display("[TB] FAIL mid_init_done got=%b exp=0", initDone); end
    #1; checks++; if (sramA !== 5'd0 || {sramCsb, sramWeb} !== 2'b00) begin errors++; $display("[TB] FAIL mid_init_start a=%0d ctrl=%b", sramA, {sramCsb, sramWeb}); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      checks++; if (respValid !== 2'b00) begin errors++; $display("[TB] FAIL mid_no_resp_late got=%b exp=00", respValid); end
      #1; checks++; if (sramA !== AW'(k)) begin errors++; $display("[TB] FAIL mid_cnt got=%0d exp=%0d", sramA, k); end
    end
    waited = 0;
    while (initDone !== 1'b1 && waited < 64) begin
      @(negedge clock);
      waited++;
    end
    checks++; if (initDone !== 1'b1 || waited != DEPTH - 4) begin errors++; $display("[TB] FAIL mid_reinit done=%b waited=%0d exp=%0d", initDone, waited, DEPTH - 4); end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) macroMem[k] = DW'({$urandom(), $urandom()});
    macroQ    = DW'({$urandom(), $urandom()});
    reset     = 1'b1;
    reqValid  = 2'b00;
    reqWe     = 2'b00;
    reqAddr   = '0;
    reqWdata  = '0;
    respReady = 2'b11;
    test_reset();
    test_init();
    test_init_reads();
    test_write_read();
    test_alternating();
    test_backpressure();
    test_ordering();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
